// File: rtl/fifo_rd_stream.sv
// Read-side adapter: issues FIFO reads and turns the one-cycle-latency read data
// into a valid/ready stream through a 3-entry skid buffer.
module fifo_rd_stream #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             rd_clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic [1:0]       buf_level,
    output logic [CNT_W-1:0] xfer_count
);
    localparam int unsigned DEPTH = 3;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [1:0]       head;
    logic [1:0]       tail;
    logic [1:0]       occ;
    logic             infl;
    logic [CNT_W-1:0] xfer_q;

    logic [1:0]       head_nxt;
    logic [1:0]       tail_nxt;
    logic [1:0]       occ_nxt;
    logic [2:0]       committed;
    logic             push;
    logic             pop;

    // Read issue, buffer bookkeeping and next-state pointers
    always_comb begin
        committed  = 3'(occ) + 3'(infl);
        fifo_rd_en = en & ~fifo_empty & (committed < 3'(DEPTH)) & rst_n;
        push       = infl;
        pop        = (occ != 2'd0) & m_ready;
        head_nxt   = head;
        tail_nxt   = tail;
        occ_nxt    = occ;
        if (pop) begin
            head_nxt = (head == 2'(DEPTH - 1)) ? 2'd0 : head + 2'd1;
        end
        if (push) begin
            tail_nxt = (tail == 2'(DEPTH - 1)) ? 2'd0 : tail + 2'd1;
        end
        case ({push, pop})
            2'b10:   occ_nxt = occ + 2'd1;
            2'b01:   occ_nxt = occ - 2'd1;
            default: occ_nxt = occ;
        endcase
    end

    // Head entry drives the stream; explicit mux keeps index within the 3 entries
    always_comb begin
        case (head)
            2'd1:    m_data = mem[1];
            2'd2:    m_data = mem[2];
            default: m_data = mem[0];
        endcase
    end

    assign m_valid    = (occ != 2'd0);
    assign buf_level  = occ;
    assign xfer_count = xfer_q;

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            head   <= 2'd0;
            tail   <= 2'd0;
            occ    <= 2'd0;
            infl   <= 1'b0;
            xfer_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            head <= head_nxt;
            tail <= tail_nxt;
            occ  <= occ_nxt;
            infl <= fifo_rd_en;
            if (pop) begin
                xfer_q <= xfer_q + CNT_W'(1);
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (push && (tail == 2'(i))) begin
                    mem[i] <= fifo_dout;
                end
            end
        end
    end
endmodule
